// File: rtl/dcache_pkg.sv
// Shared types and address-field constants for the direct-mapped data cache.
package dcache_pkg;

    // Miss-handling controller states.
    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        UPDATE
    } state_t;

    // Byte address layout: [7:5] tag, [4:2] index, [1:0] byte offset.
    localparam int OFFSET_LSB  = 0;
    localparam int INDEX_LSB   = 2;
    localparam int TAG_LSB     = 5;
    localparam int OFFSET_BITS = 2;

    // One block is four bytes, byte 0 in the low lane.
    localparam int BLOCK_BITS  = 32;

endpackage

// File: rtl/dcache_array.sv
// Block storage: data, tag, valid and dirty per line. One combinational read
// port, and a write port that updates either one byte or a whole block.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [INDEX_BITS-1:0]  rd_index,
    output logic [BLOCK_BITS-1:0]  rd_data,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic                   rd_valid,
    output logic                   rd_dirty,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic                   byte_we,
    input  logic [OFFSET_BITS-1:0] byte_offset,
    input  logic [7:0]             byte_data,
    input  logic                   block_we,
    input  logic [TAG_BITS-1:0]    block_tag,
    input  logic [BLOCK_BITS-1:0]  block_data
);

    localparam int NUM_BLOCKS = 1 << INDEX_BITS;

    logic [BLOCK_BITS-1:0] data_mem [NUM_BLOCKS];
    logic [TAG_BITS-1:0]   tag_mem  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid;
    logic [NUM_BLOCKS-1:0] dirty;

    assign rd_data  = data_mem[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid[rd_index];
    assign rd_dirty = dirty[rd_index];

    // Line status: a refill makes the line valid and clean, a byte store dirties it.
    // NOTE: clocked blocks use non-blocking assignments so every reader in the same edge sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (block_we) begin
            valid[wr_index] <= 1'b1;
            dirty[wr_index] <= 1'b0;
        end else if (byte_we) begin
            dirty[wr_index] <= 1'b1;
        end
    end

    // Data and tag payload; writes are suppressed while reset is asserted.
    // NOTE: the data and tag arrays have no reset; valid=0 already makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (block_we) begin
                data_mem[wr_index] <= block_data;
                tag_mem[wr_index]  <= block_tag;
            end else if (byte_we) begin
                data_mem[wr_index][{byte_offset, 3'b000} +: 8] <= byte_data;
            end
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate byte data cache with a block-wide
// memory interface. Hits complete in the request cycle; misses stall the CPU
// through an optional writeback, a refill and a one-cycle array update.
module dcache
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           READ,
    input  logic                           WRITE,
    input  logic [7:0]                     ADDRESS,
    input  logic [7:0]                     WRITEDATA,
    output logic [7:0]                     READDATA,
    output logic                           BUSYWAIT,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [TAG_BITS+INDEX_BITS-1:0] mem_address,
    output logic [BLOCK_BITS-1:0]          mem_writedata,
    input  logic [BLOCK_BITS-1:0]          mem_readdata,
    input  logic                           mem_busywait
);

    state_t                  state_q, state_d;
    logic                    first_q;        // first cycle of the current state
    logic [INDEX_BITS-1:0]   miss_index_q;
    logic [TAG_BITS-1:0]     miss_tag_q;
    logic [BLOCK_BITS-1:0]   fill_q;

    logic [TAG_BITS-1:0]     cpu_tag;
    logic [INDEX_BITS-1:0]   cpu_index;
    logic [OFFSET_BITS-1:0]  cpu_offset;
    logic                    req;
    logic                    hit;
    logic                    idle_hit;

    logic [INDEX_BITS-1:0]   rd_index;
    logic [BLOCK_BITS-1:0]   rd_data;
    logic [TAG_BITS-1:0]     rd_tag;
    logic                    rd_valid;
    logic                    rd_dirty;
    logic [INDEX_BITS-1:0]   wr_index;
    logic                    byte_we;
    logic                    block_we;
    logic                    latch_miss;
    logic                    capture;

    assign cpu_tag    = ADDRESS[TAG_LSB +: TAG_BITS];
    assign cpu_index  = ADDRESS[INDEX_LSB +: INDEX_BITS];
    assign cpu_offset = ADDRESS[OFFSET_LSB +: OFFSET_BITS];
    assign req        = READ | WRITE;

    // While a miss is in flight the array is addressed by the latched miss line,
    // so the victim block and its tag stay stable even if the CPU drops the request.
    assign rd_index = (state_q == IDLE) ? cpu_index : miss_index_q;
    assign wr_index = (state_q == UPDATE) ? miss_index_q : cpu_index;

    assign hit      = rd_valid && (rd_tag == cpu_tag);
    assign idle_hit = (state_q == IDLE) && hit;
    assign BUSYWAIT = req && !idle_hit;
    assign READDATA = (READ && idle_hit) ? rd_data[{cpu_offset, 3'b000} +: 8] : 8'h00;

    assign mem_writedata = (state_q == WRITEBACK) ? rd_data : '0;

    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk         (CLK),
        .reset_n     (RESET),
        .rd_index    (rd_index),
        .rd_data     (rd_data),
        .rd_tag      (rd_tag),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .wr_index    (wr_index),
        .byte_we     (byte_we),
        .byte_offset (cpu_offset),
        .byte_data   (WRITEDATA),
        .block_we    (block_we),
        .block_tag   (miss_tag_q),
        .block_data  (fill_q)
    );

    // Next-state logic and memory-side request outputs.
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        byte_we     = 1'b0;
        block_we    = 1'b0;
        latch_miss  = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        byte_we = WRITE;
                    end else begin
                        latch_miss = 1'b1;
                        state_d    = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {rd_tag, miss_index_q};
                if (!first_q && !mem_busywait) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = {miss_tag_q, miss_index_q};
                if (!first_q && !mem_busywait) begin
                    capture = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                block_we = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; first_q marks the entry cycle so a stale mem_busywait=0 is ignored.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
        end
    end

    // Miss line capture and refill buffer; only meaningful outside IDLE.
    always_ff @(posedge CLK) begin
        if (latch_miss) begin
            miss_index_q <= cpu_index;
            miss_tag_q   <= cpu_tag;
        end
        if (capture) begin
            fill_q <= mem_readdata;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed vector table, multi-cycle corner
// sequences, and a randomized run scored against a flat byte-memory model.
module tb_dcache;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- block memory model ----------------
    // Sees a request at an edge, stays busy for 'lat' cycles, then drops busy
    // for one cycle with the data (read) or commits the data (write).
    logic [31:0] seed_mem [64];
    logic [31:0] bmem [64];
    bit          seeded;
    bit          m_active;
    int          m_cnt;
    int          lat = 5;

    always @(posedge CLK) begin
        if (!RESET) begin
            mem_busywait <= 1'b0;
            m_active     <= 1'b0;
            m_cnt        <= 0;
            if (!seeded) begin
                bmem   <= seed_mem;
                seeded <= 1'b1;
            end
        end else if (!m_active) begin
            if (mem_read || mem_write) begin
                m_active     <= 1'b1;
                m_cnt        <= lat;
                mem_busywait <= 1'b1;
            end
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (mem_busywait) begin
            mem_busywait <= 1'b0;
            if (mem_write) bmem[mem_address] <= mem_writedata;
            else           mem_readdata      <= bmem[mem_address];
        end else begin
            m_active <= 1'b0;
        end
    end

    // ---------------- reference model ----------------
    // The CPU view is a flat 256-byte memory; residency is tracked per line
    // only to predict stalls and writebacks.
    logic [7:0] ref_mem [256];
    logic       res_valid [8];
    logic [2:0] res_tag   [8];
    logic       res_dirty [8];

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = bmem[i / 4];
            ref_mem[i] = w[(i % 4) * 8 +: 8];
        end
        for (int i = 0; i < 8; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
            res_tag[i]   = 3'd0;
        end
    endtask

    task automatic model_update(input logic wr, input logic [7:0] a, input logic [7:0] d);
        logic [2:0] idx;
        idx = a[4:2];
        if (!(res_valid[idx] && res_tag[idx] == a[7:5])) begin
            res_valid[idx] = 1'b1;
            res_tag[idx]   = a[7:5];
            res_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_mem[a]     = d;
            res_dirty[idx] = 1'b1;
        end
    endtask

    // ---------------- access driver ----------------
    typedef struct packed {
        logic        busy_first;
        logic [15:0] cycles;
        logic [7:0]  rdata;
        logic        saw_rd;
        logic [5:0]  rd_addr;
        logic        saw_wr;
        logic [5:0]  wr_addr;
        logic [31:0] wr_data;
    } acc_t;

    // Called #1 after a rising edge; returns #1 after the edge that completes the access.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, output acc_t r);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
        r = '0;
        @(negedge CLK);
        r.busy_first = BUSYWAIT;
        while (BUSYWAIT && r.cycles < 16'd200) begin
            @(negedge CLK);
            r.cycles = r.cycles + 16'd1;
            if (mem_read && !r.saw_rd) begin
                r.saw_rd  = 1'b1;
                r.rd_addr = mem_address;
            end
            if (mem_write && !r.saw_wr) begin
                r.saw_wr  = 1'b1;
                r.wr_addr = mem_address;
                r.wr_data = mem_writedata;
            end
        end
        r.rdata = READDATA;
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic run_model_access(input string tag, input logic rd, input logic wr,
                                    input logic [7:0] a, input logic [7:0] d);
        acc_t        r;
        logic [2:0]  idx;
        logic        hit, evict;
        int          exp_cycles;
        logic [31:0] exp_wd;
        logic [7:0]  va;
        idx   = a[4:2];
        hit   = res_valid[idx] && (res_tag[idx] == a[7:5]);
        evict = !hit && res_valid[idx] && res_dirty[idx];
        exp_cycles = hit ? 0 : (evict ? 2 * lat + 6 : lat + 4);
        exp_wd = '0;
        for (int b = 0; b < 4; b++) begin
            va = {res_tag[idx], idx, b[1:0]};
            exp_wd[8 * b +: 8] = ref_mem[va];
        end
        access(rd, wr, a, d, r);
        check({tag, " busy"}, 32'(r.busy_first), 32'(!hit));
        check({tag, " cycles"}, 32'(r.cycles), 32'(exp_cycles));
        check({tag, " mem_read seen"}, 32'(r.saw_rd), 32'(!hit));
        check({tag, " mem_write seen"}, 32'(r.saw_wr), 32'(evict));
        if (!hit) check({tag, " alloc addr"}, 32'(r.rd_addr), 32'({a[7:5], idx}));
        if (evict) begin
            check({tag, " wb addr"}, 32'(r.wr_addr), 32'({res_tag[idx], idx}));
            check({tag, " wb data"}, r.wr_data, exp_wd);
        end
        if (rd && !wr) check({tag, " rdata"}, 32'(r.rdata), 32'(ref_mem[a]));
        model_update(wr, a, d);
    endtask

    task automatic do_reset();
        RESET = 1'b0; READ = 1'b0; WRITE = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic        exp_busy;
        int          exp_cycles;
        logic        chk_rdata;
        logic [7:0]  exp_rdata;
        logic        exp_saw_rd;
        logic [5:0]  exp_rd_addr;
        logic        exp_saw_wr;
        logic [5:0]  exp_wr_addr;
        logic [31:0] exp_wr_data;
    } vec_t;

    vec_t tbl [9];

    initial begin
        acc_t r;
        RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
        for (int i = 0; i < 64; i++) seed_mem[i] = $urandom;
        seed_mem[6'h09] = 32'hDDCCBBAA;
        seed_mem[6'h39] = 32'h44332211;
        seed_mem[6'h04] = 32'h0F0E0D0C;
        seed_mem[6'h0C] = 32'h99887766;

        // With 5 busy cycles: clean miss stalls 1+7+1=9 cycles, dirty miss 1+7+7+1=16.
        tbl[0] = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b1, 9,  1'b1, 8'hAA, 1'b1, 6'h09, 1'b0, 6'h00, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 8'h27, 8'h00, 1'b0, 0,  1'b1, 8'hDD, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 8'h25, 8'h5A, 1'b0, 0,  1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 8'h25, 8'h00, 1'b0, 0,  1'b1, 8'h5A, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        tbl[4] = '{1'b1, 1'b0, 8'hE4, 8'h00, 1'b1, 16, 1'b1, 8'h11, 1'b1, 6'h39, 1'b1, 6'h09, 32'hDDCC5AAA};
        tbl[5] = '{1'b0, 1'b1, 8'h10, 8'h77, 1'b1, 9,  1'b0, 8'h00, 1'b1, 6'h04, 1'b0, 6'h00, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 0,  1'b1, 8'h77, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 8'h25, 8'h00, 1'b1, 9,  1'b1, 8'h5A, 1'b1, 6'h09, 1'b0, 6'h00, 32'h0};
        tbl[8] = '{1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 16, 1'b1, 8'h66, 1'b1, 6'h0C, 1'b1, 6'h04, 32'h0F0E0D77};

        do_reset();

        // Idle state after reset.
        @(negedge CLK);
        check("reset BUSYWAIT", 32'(BUSYWAIT), 32'd0);
        check("reset READDATA", 32'(READDATA), 32'd0);
        check("reset mem_read", 32'(mem_read), 32'd0);
        check("reset mem_write", 32'(mem_write), 32'd0);
        @(posedge CLK);
        #1;

        lat = 5;
        for (int i = 0; i < 9; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, r);
            check($sformatf("tbl%0d busy", i), 32'(r.busy_first), 32'(tbl[i].exp_busy));
            check($sformatf("tbl%0d cycles", i), 32'(r.cycles), 32'(tbl[i].exp_cycles));
            check($sformatf("tbl%0d mem_read seen", i), 32'(r.saw_rd), 32'(tbl[i].exp_saw_rd));
            check($sformatf("tbl%0d mem_write seen", i), 32'(r.saw_wr), 32'(tbl[i].exp_saw_wr));
            if (tbl[i].chk_rdata)
                check($sformatf("tbl%0d rdata", i), 32'(r.rdata), 32'(tbl[i].exp_rdata));
            if (tbl[i].exp_saw_rd)
                check($sformatf("tbl%0d alloc addr", i), 32'(r.rd_addr), 32'(tbl[i].exp_rd_addr));
            if (tbl[i].exp_saw_wr) begin
                check($sformatf("tbl%0d wb addr", i), 32'(r.wr_addr), 32'(tbl[i].exp_wr_addr));
                check($sformatf("tbl%0d wb data", i), r.wr_data, tbl[i].exp_wr_data);
            end
            model_update(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
        end

        // Reset asserted in the third ALLOCATE cycle abandons the refill.
        READ = 1'b1; ADDRESS = 8'h48;
        @(posedge CLK);          // enters ALLOCATE
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("abort alloc mem_read before", 32'(mem_read), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        check("abort mem_read after", 32'(mem_read), 32'd0);
        check("abort mem_write after", 32'(mem_write), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1; READ = 1'b0;
        model_reset();
        run_model_access("reread after reset", 1'b1, 1'b0, 8'h24, 8'h00);

        // READ and WRITE together on a hit behave as a store.
        run_model_access("rw store", 1'b1, 1'b1, 8'h24, 8'hC3);
        run_model_access("rw readback", 1'b1, 1'b0, 8'h24, 8'h00);
        run_model_access("rw evict", 1'b1, 1'b0, 8'hE4, 8'h00);

        // A request dropped mid-miss still completes the refill.
        lat = 3;
        READ = 1'b1; ADDRESS = 8'h6C;
        repeat (2) @(posedge CLK);
        #1;
        READ = 1'b0;
        repeat (30) @(posedge CLK);
        @(negedge CLK);
        check("drop idle mem_read", 32'(mem_read), 32'd0);
        @(posedge CLK);
        #1;
        model_update(1'b0, 8'h6C, 8'h00);
        run_model_access("drop rehit", 1'b1, 1'b0, 8'h6D, 8'h00);

        // Randomized traffic over a few conflicting tags and four lines.
        for (int n = 0; n < 120; n++) begin
            logic [2:0] tg;
            logic [7:0] a;
            int         op;
            lat = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
                0:       tg = 3'd2;
                1:       tg = 3'd5;
                default: tg = 3'd6;
            endcase
            a  = {tg, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            op = $urandom_range(0, 2);
            run_model_access($sformatf("rnd%0d", n), op != 1, op != 0, a, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
